// File: rtl/fifo_pkg.sv
// Shared definitions for the sync FIFO family: read-mode encoding and depth legality helpers.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int FIFO_MIN_DEPTH = 4;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register-array storage: synchronous write, asynchronous read.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  // Contents are deliberately left unreset; validity is tracked by the pointers.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    always_ff @(posedge clk) begin
      if (we && (waddr == ADDR_W'(e))) mem[e] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with selectable standard/FWFT read, programmable almost-full/empty,
// occupancy count, synchronous flush and sticky overflow/underflow status.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  parameter  int FWFT       = 0,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int CNT_W      = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [CNT_W-1:0]      count,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic                  full,
  output logic                  empty,
  output logic                  half_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  write_error,
  output logic                  read_error,
  output logic                  overflow,
  output logic                  underflow
);

  localparam fifo_mode_e       MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(DEPTH / 2);

  if (!is_pow2(DEPTH) || (DEPTH < FIFO_MIN_DEPTH)) begin : g_bad_depth
    $error("sync_fifo_prog: DEPTH must be a power of 2 and >= %0d", FIFO_MIN_DEPTH);
  end

  logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  werr_q, rerr_q, ovf_q, unf_q;
  logic                  rd_acc, wr_acc, op_en;

  // Flags decode the registered count against live thresholds.
  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_C);
  assign half_full    = (cnt >= HALF_C);
  assign almost_full  = (cnt >= af_thresh);
  assign almost_empty = (cnt <= ae_thresh);
  assign count        = cnt;

  // A read frees a slot in the same cycle, so a full FIFO still takes a concurrent write.
  assign op_en  = rst_n && !flush;
  assign rd_acc = r_en && !empty;
  assign wr_acc = w_en && (!full || rd_acc);

  assign write_error = werr_q;
  assign read_error  = rerr_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && op_en),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      werr_q <= 1'b0;
      rerr_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      werr_q <= w_en && !wr_acc;
      rerr_q <= r_en && !rd_acc;
      ovf_q  <= ovf_q || (w_en && !wr_acc);
      unf_q  <= unf_q || (r_en && !rd_acc);
    end
  end

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dv_q;

    // Flush drops the valid pulse but keeps the last word on the bus.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else if (flush) begin
        dv_q   <= 1'b0;
      end else begin
        dv_q <= rd_acc;
        if (rd_acc) dout_q <= rdata;
      end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
  end else begin : g_fwft
    assign data_out   = rdata;
    assign data_valid = !empty;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: standard and FWFT instances share stimulus and a queue-based reference.
module tb_sync_fifo_prog;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, flush = 1'b0, w_en = 1'b0, r_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [CW-1:0] af_thresh = '0, ae_thresh = '0;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_dv, f_dv;
  logic [CW-1:0] s_count, f_count;
  logic          s_full, s_empty, s_half, s_af, s_ae, s_werr, s_rerr, s_ov, s_un;
  logic          f_full, f_empty, f_half, f_af, f_ae, f_werr, f_rerr, f_ov, f_un;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(s_dout), .data_valid(s_dv), .count(s_count), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .full(s_full), .empty(s_empty), .half_full(s_half),
    .almost_full(s_af), .almost_empty(s_ae), .write_error(s_werr), .read_error(s_rerr),
    .overflow(s_ov), .underflow(s_un));

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(f_dout), .data_valid(f_dv), .count(f_count), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .full(f_full), .empty(f_empty), .half_full(f_half),
    .almost_full(f_af), .almost_empty(f_ae), .write_error(f_werr), .read_error(f_rerr),
    .overflow(f_ov), .underflow(f_un));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: contents as a queue plus the registered status a reader would see.
  logic [DW-1:0] q[$];
  bit            m_werr, m_rerr, m_ov, m_un, m_dv;
  logic [DW-1:0] m_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int n;
    bit rd_ok, wr_ok;
    n = q.size();
    if (!rst_n || flush) begin
      q.delete();
      m_werr = 0; m_rerr = 0; m_ov = 0; m_un = 0; m_dv = 0;
      if (!rst_n) m_dout = '0;
    end else begin
      rd_ok  = r_en && (n > 0);
      wr_ok  = w_en && ((n < DEPTH) || rd_ok);
      m_dv   = rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(data_in);
      m_werr = w_en && !wr_ok;
      m_rerr = r_en && !rd_ok;
      m_ov   = m_ov || m_werr;
      m_un   = m_un || m_rerr;
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("count",        32'(s_count), 32'(n));
    chk("full",         32'(s_full),  32'(n == DEPTH));
    chk("empty",        32'(s_empty), 32'(n == 0));
    chk("half_full",    32'(s_half),  32'(n >= DEPTH / 2));
    chk("almost_full",  32'(s_af),    32'(n >= int'(af_thresh)));
    chk("almost_empty", 32'(s_ae),    32'(n <= int'(ae_thresh)));
    chk("write_error",  32'(s_werr),  32'(m_werr));
    chk("read_error",   32'(s_rerr),  32'(m_rerr));
    chk("overflow",     32'(s_ov),    32'(m_ov));
    chk("underflow",    32'(s_un),    32'(m_un));
    chk("std_valid",    32'(s_dv),    32'(m_dv));
    chk("std_dout",     32'(s_dout),  32'(m_dout));
    chk("fw_count",     32'(f_count), 32'(n));
    chk("fw_valid",     32'(f_dv),    32'(n > 0));
    chk("fw_werr",      32'(f_werr),  32'(m_werr));
    chk("fw_rerr",      32'(f_rerr),  32'(m_rerr));
    if (n > 0) chk("fw_dout", 32'(f_dout), 32'(q[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic drive(input bit rn, input bit fl, input bit w, input logic [DW-1:0] d, input bit r);
    rst_n = rn; flush = fl; w_en = w; data_in = d; r_en = r;
  endtask

  task automatic idle();
    drive(1, 0, 0, 8'h00, 0);
  endtask

  typedef struct {
    bit            f, w, r;
    logic [DW-1:0] d;
    logic [CW-1:0] cnt;
    bit            rerr, dv, un;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Reset state
    drive(0, 0, 1, 8'hFF, 1);
    tick();
    tick();
    chk("rst_count", 32'(s_count), 0);
    chk("rst_empty", 32'(s_empty), 1);
    chk("rst_af_at_zero_thresh", 32'(s_af), 1);
    chk("rst_ae", 32'(s_ae), 1);
    chk("rst_dout", 32'(s_dout), 0);

    // Table: empty corners, flush holding std data_out
    af_thresh = 12; ae_thresh = 3;
    vecs = '{
      '{0, 1, 1, 8'h11, 1, 1, 0, 1, 8'h00},
      '{0, 0, 1, 8'h00, 0, 0, 1, 1, 8'h11},
      '{0, 0, 1, 8'h00, 0, 1, 0, 1, 8'h11},
      '{0, 1, 0, 8'h22, 1, 0, 0, 1, 8'h11},
      '{1, 1, 0, 8'h44, 0, 0, 0, 0, 8'h11},
      '{0, 1, 0, 8'h33, 1, 0, 0, 0, 8'h11},
      '{0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h11},
      '{0, 0, 1, 8'h00, 0, 0, 1, 0, 8'h33}
    };
    for (int i = 0; i < 8; i++) begin
      drive(1, vecs[i].f, vecs[i].w, vecs[i].d, vecs[i].r);
      tick();
      chk($sformatf("vec%0d_count", i), 32'(s_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_rerr", i),  32'(s_rerr),  32'(vecs[i].rerr));
      chk($sformatf("vec%0d_dv", i),    32'(s_dv),    32'(vecs[i].dv));
      chk($sformatf("vec%0d_un", i),    32'(s_un),    32'(vecs[i].un));
      chk($sformatf("vec%0d_dout", i),  32'(s_dout),  32'(vecs[i].dout));
    end

    // 1: fill 0..15 then drain in order
    drive(1, 1, 0, 0, 0); tick();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 1, DW'(i), 0);
      tick();
      if (i == 6) chk("t1_half_at7", 32'(s_half), 0);
      if (i == 7) chk("t1_half_at8", 32'(s_half), 1);
      if (i == 14) chk("t1_full_at15", 32'(s_full), 0);
    end
    chk("t1_full", 32'(s_full), 1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 0, 1);
      tick();
      chk("t1_drain_dout", 32'(s_dout), 32'(i));
      chk("t1_drain_dv", 32'(s_dv), 1);
    end
    idle(); tick();
    chk("t1_dv_drop", 32'(s_dv), 0);
    chk("t1_empty", 32'(s_empty), 1);

    // 2: overflow, then simultaneous read/write while full
    for (int i = 0; i < DEPTH; i++) begin drive(1, 0, 1, DW'(8'h10 + i), 0); tick(); end
    drive(1, 0, 1, 8'hAA, 0); tick();
    chk("t2_werr", 32'(s_werr), 1);
    chk("t2_ovf", 32'(s_ov), 1);
    idle(); tick();
    chk("t2_werr_pulse", 32'(s_werr), 0);
    chk("t2_ovf_sticky", 32'(s_ov), 1);
    drive(1, 0, 1, 8'hBB, 1); tick();
    chk("t2_count_full_rw", 32'(s_count), 16);
    chk("t2_oldest", 32'(s_dout), 32'h10);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 0, 1); tick();
      chk("t2_drain", 32'(s_dout), (i < 15) ? 32'(8'h11 + i) : 32'hBB);
    end

    // 3: underflow and write+read on empty
    drive(1, 0, 0, 0, 1); tick();
    chk("t3_rerr", 32'(s_rerr), 1);
    chk("t3_unf", 32'(s_un), 1);
    chk("t3_dv", 32'(s_dv), 0);
    drive(1, 0, 1, 8'h77, 1); tick();
    chk("t3_rw_count", 32'(s_count), 1);
    chk("t3_rw_rerr", 32'(s_rerr), 1);

    // 4: thresholds, including a same-cycle threshold change
    drive(1, 1, 0, 0, 0); tick();
    af_thresh = 12; ae_thresh = 3;
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 1, DW'($urandom), 0); tick();
      if (i == 10) chk("t4_af_11", 32'(s_af), 0);
      if (i == 11) chk("t4_af_12", 32'(s_af), 1);
    end
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 0, 1); tick();
      if (i == 7) chk("t4_ae_4", 32'(s_ae), 0);
      if (i == 8) chk("t4_ae_3", 32'(s_ae), 1);
    end
    for (int i = 0; i < 5; i++) begin drive(1, 0, 1, DW'($urandom), 0); tick(); end
    chk("t4_af_8_thr12", 32'(s_af), 0);
    af_thresh = 5;
    #1;
    chk("t4_af_live", 32'(s_af), 1);
    af_thresh = 20;
    for (int i = 0; i < 8; i++) begin drive(1, 0, 1, DW'($urandom), 0); tick(); end
    chk("t4_af_over_depth", 32'(s_af), 0);

    // 5: FWFT fall-through and pointer wrap
    drive(1, 1, 0, 0, 0); tick();
    drive(1, 0, 1, 8'h5A, 0); tick();
    chk("t5_fw_dout", 32'(f_dout), 32'h5A);
    chk("t5_fw_dv", 32'(f_dv), 1);
    drive(1, 0, 0, 0, 1); tick();
    chk("t5_fw_empty", 32'(f_empty), 1);
    chk("t5_fw_dv0", 32'(f_dv), 0);
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 1, DW'(8'h80 + i), i >= 2);
      tick();
      if (i >= 2) chk("t5_wrap_head", 32'(f_dout), 32'(8'h80 + i - 1));
    end

    // 6: flush and reset mid-operation
    idle(); drive(1, 1, 0, 0, 0); tick();
    for (int i = 0; i < DEPTH + 1; i++) begin drive(1, 0, 1, DW'(i), 0); tick(); end
    for (int i = 0; i < 7; i++) begin drive(1, 0, 0, 0, 1); tick(); end
    chk("t6_pre_count", 32'(s_count), 9);
    chk("t6_pre_ovf", 32'(s_ov), 1);
    drive(1, 1, 1, 8'hEE, 0); tick();
    chk("t6_fl_count", 32'(s_count), 0);
    chk("t6_fl_empty", 32'(s_empty), 1);
    chk("t6_fl_ovf", 32'(s_ov), 0);
    chk("t6_fl_werr", 32'(s_werr), 0);
    drive(1, 0, 1, 8'h3C, 0); tick();
    drive(1, 0, 0, 0, 1); tick();
    chk("t6_fl_data", 32'(s_dout), 32'h3C);
    for (int i = 0; i < 5; i++) begin drive(1, 0, 1, DW'(i), 0); tick(); end
    drive(0, 0, 1, 8'hEE, 1); tick();
    chk("t6_rst_dout", 32'(s_dout), 0);
    chk("t6_rst_count", 32'(s_count), 0);
    drive(1, 0, 1, 8'h5C, 0); tick();
    drive(1, 0, 0, 0, 1); tick();
    chk("t6_rst_data", 32'(s_dout), 32'h5C);

    // Randomised traffic against the reference
    begin
      int wb, rb;
      wb = 50; rb = 50;
      for (int c = 0; c < 800; c++) begin
        if (c % 100 == 0) begin wb = $urandom_range(90, 10); rb = $urandom_range(90, 10); end
        if (c % 25 == 0) begin
          af_thresh = CW'($urandom_range(20, 0));
          ae_thresh = CW'($urandom_range(20, 0));
        end
        drive(($urandom % 200) != 0, ($urandom % 60) == 0, ($urandom % 100) < wb,
              DW'($urandom), ($urandom % 100) < rb);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
